dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Responder end of the core's data-memory request/response interface. Accepts one
//   load/store request at a time from the datapath's memory-access side over a
//   valid/ready handshake. Applies a programmable access latency and byte-lane writes,
//   then returns read data (or a store acknowledge) over a second valid/ready channel.
//   Replaces the zero-wait data memory once the core moves to a stalling memory port.
// PARAMETERS
//   DEPTH_WORDS  256  number of 32-bit words stored; power of two
//   LATENCY      2    wait cycles between request accept and memory access; 0..15
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, lane i = bits [8i+7:8i]
//   req_be     in   4   store byte enables; ignored for loads
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts response
//   rsp_rdata  out  32  load data; 0 for stores
//   rsp_err    out  1   misaligned-access flag; constant 0 unless MISALIGN_ERR_EN
// BEHAVIOUR
//   - Reset (async, active-high): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//     latency counter=0. req_ready=0 while rst is high. Memory array is NOT reset.
//   - FSM IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be.
//       Load counter with LATENCY. Go to WAIT, or directly to the access edge if LATENCY=0.
//     WAIT: req_ready=0. Decrement each cycle. At count 0, perform the access; go to RESP.
//     RESP: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready; then go to IDLE.
//   - Latency: accept at edge N -> rsp_valid high from edge N+1+LATENCY.
//     Minimum request-to-request spacing is LATENCY+3 cycles with rsp_ready tied 1.
//     Not pipelined: no second accept until the response handshake completes.
//   - Store: at the access edge, each lane i with be[i]=1 is written from wdata lane i.
//     be=4'b0000 writes nothing but still responds. rsp_rdata=0.
//   - Load: rsp_rdata = full word at the access edge. A store is visible to the next load.
//   - Addressing: word index = req_addr[log2(DEPTH_WORDS)+1:2].
//     Upper bits are ignored, so access wraps modulo the depth.
//   - Back-pressure: rsp_ready low holds RESP indefinitely with rdata/err unchanged.
//     req_valid is ignored while not IDLE.
//   - Reset mid-transaction: pending access is dropped. A store that has not reached its
//     access edge never writes. rsp_valid drops asynchronously.
// CONFIGURATION
//   MISALIGN_ERR_EN defined:
//     - Misaligned request (load or store with req_addr[1:0]!=0) sets rsp_err=1 and is
//       suppressed: no write, rsp_rdata=0. Latency is unchanged.
//     - Aligned requests return rsp_err=0.
//   MISALIGN_ERR_EN undefined:
//     - req_addr[1:0] is ignored; every access is word-aligned.
//     - rsp_err is tied 0.
// STRUCTURE
//   - dmem_pkg: FSM state encoding (IDLE/WAIT/RESP), BE_W=4, WORD_BYTES=4, counter width.
//   - Sub-module dmem_array: DEPTH_WORDS x 32 synchronous single-port RAM.
//     Per-lane write enables, registered read; no reset.
//   - dmem_responder: handshake FSM, request latches, latency counter, response registers.
// TESTING
//   1 Reset, then load 0x0000_0010 (LATENCY=2) -> req_ready=1 after rst falls;
//     rsp_valid rises exactly 3 cycles after accept.
//   2 Store 0xDEADBEEF be=1111 @0x20, then load @0x20 -> rsp_rdata=0xDEADBEEF;
//     store rsp_rdata=0.
//   3 Store 0x11223344 be=0101 over 0xDEADBEEF @0x20, then load -> rsp_rdata=0xDE22BE44.
//   4 Hold rsp_ready=0 for 10 cycles during RESP -> rsp_valid/rdata stable,
//     req_ready=0, and a req_valid pulse is not accepted.
//   5 Store @0x400 with DEPTH_WORDS=256, then load @0x000 -> wraps, same data returned.
//   6 Assert rst during WAIT of a store -> rsp_valid=0 immediately;
//     later load of that address returns the old value.
//     With MISALIGN_ERR_EN, a load @0x22 returns rsp_err=1 and rsp_rdata=0.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the data-memory responder:
//            handshake FSM state encoding, lane geometry, latency counter width.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte lanes per 32-bit word
    localparam int BE_W       = 4;
    localparam int WORD_BYTES = 4;

    // Latency counter covers LATENCY values 0..15
    localparam int CNT_W      = 4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : DEPTH_WORDS x 32 synchronous single-port RAM with per-byte-lane
//            write enables and a registered read port. Contents are not reset.
// Revision : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic [BE_W-1:0] i_we,
    input  logic            i_re,
    input  logic [AW-1:0]   i_addr,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Lane-masked write and registered read; read data holds until the next read
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Responder side of the core data-memory request/response port.
//            Accepts one load/store at a time, waits LATENCY cycles, performs
//            the access on dmem_array and returns data/ack on a valid/ready
//            response channel.
// Config   : MISALIGN_ERR_EN - when defined, requests with addr[1:0] != 0 are
//            suppressed and answered with rsp_err=1, rsp_rdata=0.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err
);

    localparam int C_IDX_W = $clog2(DEPTH_WORDS);
    localparam int C_LSB   = $clog2(WORD_BYTES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [C_IDX_W-1:0]  r_idx;
    logic [31:0]         r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_mis;
    logic                r_rsp_load;
    logic                r_rsp_err;

    logic                w_req_mis;
    logic                w_take;
    logic                w_access;
    logic [BE_W-1:0]     w_ram_we;
    logic                w_ram_re;
    logic [31:0]         w_ram_rdata;

    // Address bits above the word index never select storage (access wraps)
    logic                w_unused_addr;
    assign w_unused_addr = ^{req_addr[31:C_IDX_W+C_LSB], req_addr[C_LSB-1:0]};

`ifdef MISALIGN_ERR_EN
    assign w_req_mis = (req_addr[C_LSB-1:0] != '0);
`else
    assign w_req_mis = 1'b0;
`endif

    // A request is taken whenever it is presented in IDLE (reset has priority in the flops)
    assign w_take   = (r_state == ST_IDLE) && req_valid;
    // The access edge is the WAIT cycle whose count has reached zero
    assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latches and latency counter; LATENCY=0 reaches the access edge one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_mis   <= 1'b0;
        end else if (w_take) begin
            r_cnt   <= CNT_W'(LATENCY);
            r_we    <= req_we;
            r_idx   <= req_addr[C_IDX_W+C_LSB-1:C_LSB];
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_mis   <= w_req_mis;
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Response qualifiers, set at the access edge and cleared on the response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_load <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_access) begin
            r_rsp_load <= !r_we && !r_mis;
            r_rsp_err  <= r_mis;
        end else if (rsp_valid && rsp_ready) begin
            r_rsp_load <= 1'b0;
            r_rsp_err  <= 1'b0;
        end
    end

    // Suppressed (misaligned) accesses touch neither the write nor the read port
    assign w_ram_we = {BE_W{w_access && r_we && !r_mis}} & r_be;
    assign w_ram_re = w_access && !r_we && !r_mis;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (C_IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM read register holds during RESP, so gating by the load flag keeps rdata stable
    assign rsp_rdata = r_rsp_load ? w_ram_rdata : 32'h0;
    assign rsp_err   = r_rsp_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder: directed scenarios plus
//            randomized loads/stores against a word-array reference model.
// Config   : honours MISALIGN_ERR_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [DEPTH];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_mis(input logic [31:0] a);
`ifdef MISALIGN_ERR_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Apply a request to the reference model and return the expected response
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] e_rd, output logic e_err);
        int idx;
        idx   = int'((addr / 4) % DEPTH);
        e_err = is_mis(addr);
        e_rd  = 32'h0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                e_rd = mdl[idx];
            end
        end
    endtask

    // One full transaction with optional response back-pressure of 'hold' cycles
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input logic chk_data,
                          output logic [31:0] rd, output logic er);
        logic [31:0] e_rd;
        logic [31:0] held;
        logic        e_err;
        int          n;
        int          lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
        @(posedge clk);
        model_access(we, addr, wdata, be, e_rd, e_err);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check("busy_ready", req_ready, 0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT + 1);
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, held);
            check("hold_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        if (chk_data) check("rdata", rsp_rdata, e_rd);
        check("err", rsp_err, e_err);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle_ready", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);

        // Load right after reset: latency only (memory content undefined)
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);

        // Fill the whole memory so every later load has a defined expectation
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b1, rd, er);
        end

        // Full store then load
        do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0, 1'b1, rd, er);
        check("t2_store_rdata", rd, 32'h0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("t2_load", rd, 32'hDEADBEEF);

        // Partial lanes
        do_req(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, 1'b1, rd, er);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("t3_lanes", rd, 32'hDE22BE44);

        // Response back-pressure with a request pulse during RESP
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 10, 1'b1, rd, er);
        check("t4_hold", rd, 32'hDE22BE44);

        // Zero byte enables write nothing
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 1'b1, rd, er);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("be_zero", rd, 32'hDE22BE44);

        // Address wrap modulo depth
        do_req(1'b1, 32'h400, 32'h5A5AA5A5, 4'hF, 0, 1'b1, rd, er);
        do_req(1'b0, 32'h000, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("t5_wrap", rd, 32'h5A5AA5A5);

        // Reset during WAIT of a store: the store must not land
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("t6_old_value", rd, 32'hDE22BE44);

        // Reset while a response is presented: rsp_valid drops without a clock edge
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("resp_seen", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_in_resp_valid", rsp_valid, 0);
        check("rst_in_resp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef MISALIGN_ERR_EN
        do_req(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("mis_load_err", er, 1);
        check("mis_load_rdata", rd, 0);
        do_req(1'b1, 32'h21, 32'h00000000, 4'hF, 0, 1'b1, rd, er);
        check("mis_store_err", er, 1);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("mis_store_nowrite", rd, 32'hDE22BE44);
`else
        do_req(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b1, rd, er);
        check("unaligned_load", rd, 32'hDE22BE44);
        check("unaligned_err", er, 0);
`endif

        // Randomized traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b1, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
